// File: rtl/stream_fifo_mc_pkg.sv
// Shared helpers for the multi-channel stream FIFO: derived widths for pointers and channel ids.
package stream_fifo_mc_pkg;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // A single-channel instance still needs a 1-bit channel field on the ports.
  function automatic int unsigned ch_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/stream_fifo_mc_ctrl.sv
// Per-channel FIFO bookkeeping: read/write pointers with non-power-of-two wrap and occupancy.
module stream_fifo_mc_ctrl import stream_fifo_mc_pkg::*; #(
  parameter int unsigned FifoDepth = 8,
  parameter int unsigned AddrWidth = ptr_width(FifoDepth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  output logic [AddrWidth-1:0] wr_ptr_o,
  output logic [AddrWidth-1:0] rd_ptr_o,
  output logic [AddrWidth:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam logic [AddrWidth-1:0] LastPtr   = AddrWidth'(FifoDepth - 1);
  localparam logic [AddrWidth:0]   FullCount = (AddrWidth + 1)'(FifoDepth);

  logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrWidth:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      if (push_i && !pop_i) begin
        count_d = count_q + 1'b1;
      end else if (!push_i && pop_i) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign full_o   = (count_q == FullCount);
  assign empty_o  = (count_q == '0);

endmodule

// File: rtl/stream_fifo_mc.sv
// Multi-channel streaming FIFO: shared storage, per-channel control, optional fall-through and a
// sticky error for transfers that address a non-existent channel.
module stream_fifo_mc import stream_fifo_mc_pkg::*; #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned FifoDepth   = 8,
  parameter int unsigned NumChannels = 4,
  parameter bit          FallThrough = 1'b0,
  parameter int unsigned AddrWidth   = ptr_width(FifoDepth),
  parameter int unsigned ChWidth     = ch_width(NumChannels)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 clr_i,
  input  logic [DataWidth-1:0]                 in_data_i,
  input  logic [ChWidth-1:0]                   in_ch_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [ChWidth-1:0]                   out_ch_i,
  output logic [DataWidth-1:0]                 out_data_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  input  logic [AddrWidth:0]                   af_thresh_i,
  output logic [NumChannels-1:0]               full_o,
  output logic [NumChannels-1:0]               empty_o,
  output logic [NumChannels-1:0]               almost_full_o,
  output logic [NumChannels*(AddrWidth+1)-1:0] count_o,
  output logic                                 err_o
);

  localparam int unsigned CntWidth = AddrWidth + 1;

  logic [NumChannels-1:0][AddrWidth-1:0] wr_ptr;
  logic [NumChannels-1:0][AddrWidth-1:0] rd_ptr;
  logic [NumChannels-1:0]                full, empty, push, pop;
  logic [DataWidth-1:0]                  mem_q [NumChannels][FifoDepth];

  logic               in_ok, out_ok, bypass, push_fire, pop_fire;
  logic               err_q, err_d;
  logic [ChWidth-1:0] in_sel, out_sel;

  // Widen before comparing so a power-of-two channel count is not a constant compare.
  assign in_ok   = 32'(in_ch_i) < NumChannels;
  assign out_ok  = 32'(out_ch_i) < NumChannels;
  assign in_sel  = in_ok ? in_ch_i : '0;
  assign out_sel = out_ok ? out_ch_i : '0;

  always_comb begin
    bypass      = FallThrough && in_valid_i && in_ok && out_ok && (in_ch_i == out_ch_i) &&
                  empty[out_sel];
    in_ready_o  = ~in_ok | ~full[in_sel];
    out_valid_o = out_ok & (~empty[out_sel] | bypass);
    out_data_o  = '0;
    if (bypass) begin
      out_data_o = in_data_i;
    end else if (out_ok) begin
      out_data_o = mem_q[out_sel][rd_ptr[out_sel]];
    end
    // A bypassed word consumed in the same cycle never touches storage.
    push_fire = in_valid_i & in_ok & ~full[in_sel] & ~(bypass & out_ready_i);
    pop_fire  = out_ready_i & out_ok & ~empty[out_sel];
    err_d     = clr_i ? 1'b0 : (err_q | (in_valid_i & ~in_ok) | (out_ready_i & ~out_ok));
  end

  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    assign push[c] = push_fire & (in_sel == ChWidth'(c));
    assign pop[c]  = pop_fire & (out_sel == ChWidth'(c));

    stream_fifo_mc_ctrl #(
      .FifoDepth (FifoDepth),
      .AddrWidth (AddrWidth)
    ) u_ctrl (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (clr_i),
      .push_i   (push[c]),
      .pop_i    (pop[c]),
      .wr_ptr_o (wr_ptr[c]),
      .rd_ptr_o (rd_ptr[c]),
      .count_o  (count_o[c*CntWidth +: CntWidth]),
      .full_o   (full[c]),
      .empty_o  (empty[c])
    );

    assign almost_full_o[c] = (count_o[c*CntWidth +: CntWidth] >= af_thresh_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
      for (int c = 0; c < NumChannels; c++) begin
        for (int i = 0; i < FifoDepth; i++) begin
          mem_q[c][i] <= '0;
        end
      end
    end else begin
      err_q <= err_d;
      if (push_fire && !clr_i) mem_q[in_sel][wr_ptr[in_sel]] <= in_data_i;
    end
  end

  assign full_o  = full;
  assign empty_o = empty;
  assign err_o   = err_q;

endmodule
